// File: rtl/coeff_loader.sv
// Coefficient bank loader: streams N complex words into a shadow bank and
// commits the whole bank to coeff_data in one edge once the framing checks out.
module coeff_loader #(
  parameter int NBITS = 11,
  parameter int N     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*NBITS-1:0]      s_data,
  input  logic                    s_last,
  output logic [NBITS*N*2-1:0]    coeff_data,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int SW = 2 * NBITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [NBITS-1:0] RE_ONE = NBITS'(1) << (NBITS - 2);
  localparam logic [SW-1:0]    UNITY  = {RE_ONE, {NBITS{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [NBITS*N*2-1:0] r_shadow;
  logic [NBITS*N*2-1:0] r_coeff;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic                w_hs;
  logic                w_at_end;
  logic [CW-1:0]       w_slot;

  assign w_hs     = s_valid & r_ready;
  assign w_at_end = (r_cnt == CW'(N - 1));
  // First word lands in the top slot, last word in slot 0.
  assign w_slot   = CW'(N - 1) - r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      for (int k = 0; k < N; k++) r_coeff[k*SW +: SW] <= UNITY;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_state <= LOAD;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          // Abort wins over a word offered in the same cycle.
          if (abort) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_hs) begin
            if (s_last != w_at_end) begin
              r_err   <= 1'b1;
              r_state <= IDLE;
              r_ready <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_shadow[w_slot*SW +: SW] <= s_data;
              r_cnt <= r_cnt + CW'(1);
              if (w_at_end) begin
                r_state <= COMMIT;
                r_ready <= 1'b0;
              end
            end
          end
        end
        COMMIT: begin
          r_coeff <= r_shadow;
          r_done  <= 1'b1;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = r_ready;
  assign coeff_data = r_coeff;
  assign load_busy  = r_busy;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule

// File: doc/coeff_loader.md
COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 SHALL have parameter NBITS, default 11: width of each real and each imaginary coefficient part, two's complement.
REQ-002 SHALL have parameter N, default 32: number of complex coefficients in the bank.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin a new bank load.
REQ-006 SHALL have port abort  input  1  discard an in-progress load.
REQ-007 SHALL have port s_valid  input  1  input coefficient word valid.
REQ-008 SHALL have port s_ready  output  1  block accepts a word this cycle.
REQ-009 SHALL have port s_data  input  2*NBITS  coefficient word: real part in [2*NBITS-1:NBITS], imaginary part in [NBITS-1:0].
REQ-010 SHALL have port s_last  input  1  marks the final (N-th) word of a load.
REQ-011 SHALL have port coeff_data  output  NBITS*N*2  packed committed bank; slot k occupies [2*NBITS*(k+1)-1 : 2*NBITS*k].
REQ-012 SHALL have port load_busy  output  1  high while a load is in progress.
REQ-013 SHALL have port load_done  output  1  one-cycle pulse on commit.
REQ-014 SHALL have port load_err  output  1  one-cycle pulse on s_last framing error.

Function
REQ-015 SHALL implement an FSM with states IDLE, LOAD and COMMIT, plus a shadow bank of NBITS*N*2 bits and a word counter 0..N-1.
REQ-016 SHALL, in IDLE, drive s_ready=0, and on start=1 clear the counter and go to LOAD.
REQ-017 SHALL, in LOAD, drive s_ready=1; a handshake is s_valid&&s_ready in the same cycle.
REQ-018 SHALL, on each handshake, write s_data into shadow slot N-1-count (first word to the MSB slot, last word to slot 0) and increment the counter.
REQ-019 SHALL, on a handshake with count==N-1 and s_last=1, go to COMMIT.
REQ-020 SHALL, on a handshake with s_last mismatching (count==N-1)?1:0, drop the word, pulse load_err in the following cycle, and return to IDLE with coeff_data unchanged.
REQ-021 SHALL, in COMMIT, drive s_ready=0, copy the whole shadow bank into coeff_data at the next edge, pulse load_done with that same edge, and return to IDLE.
REQ-022 SHALL give latency from the final handshake edge E to new coeff_data and load_done=1 at edge E+1; neither SHALL change partially before that edge.
REQ-023 SHALL, on abort=1 in LOAD, return to IDLE without writing that cycle's word, and leave coeff_data unchanged with no load_done; abort SHALL take priority over a simultaneous handshake.
REQ-024 SHALL ignore abort in IDLE and COMMIT; a commit in progress SHALL complete.
REQ-025 SHALL ignore start outside IDLE.
REQ-026 SHALL drive load_busy=1 exactly when the state is not IDLE.
REQ-027 SHALL ignore s_valid while s_ready=0; words offered then are not consumed.
REQ-028 SHALL hold coeff_data stable between commits; it is modified only by REQ-021 and by reset.

Reset
REQ-029 SHALL, when rst=1 at an edge, enter IDLE, clear the counter, and drive s_ready=0, load_busy=0, load_done=0 and load_err=0.
REQ-030 SHALL, when rst=1 at an edge, set every coeff_data slot to the unity twiddle: real = 2^(NBITS-2) (default 01000000000b), imag = 0; the default 22-bit slot is 0100000000000000000000b.
REQ-031 SHALL give rst priority over all other inputs, including reset mid-LOAD and during COMMIT; no commit occurs and the shadow contents are don't-care.

Verification
REQ-032 SHALL be covered by: reset -> all 32 slots == 22'h100000, s_ready=0, load_busy=0.
REQ-033 SHALL be covered by: start, then 32 back-to-back words with value k = word index (s_last on word 31) -> one edge later slot 31 == 0, slot 0 == 31, load_done high for exactly 1 cycle.
REQ-034 SHALL be covered by: full load with s_valid toggling 0/1 randomly -> same result as REQ-033, and no words are lost or duplicated.
REQ-035 SHALL be covered by: start, 10 words, abort asserted together with valid word 11 -> IDLE next cycle, coeff_data unchanged, no load_done.
REQ-036 SHALL be covered by: s_last=1 on word 5 -> load_err pulses once, coeff_data unchanged; s_last=0 on word 32 -> likewise.
REQ-037 SHALL be covered by: rst asserted in the COMMIT cycle -> coeff_data == unity pattern, and no load_done pulse.
